// File: rtl/fp_divider_seq.sv
// fp_divider_seq: sequential IEEE-754 single-precision style divider, result = a / b.
// Restoring mantissa division producing one quotient bit per clock, followed by a
// single normalisation step. Truncating arithmetic, no special-value handling; the
// exponent wraps modulo 2^EXP_W and zero operands are treated as normals with hidden 1.
// Optional build macro FP_DIV_ZERO_CHECK_EN adds a div_by_zero flag and a short path
// that returns a signed infinity when the divisor magnitude is zero.
module fp_divider_seq #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [EXP_W+MANT_W:0]     a,
  input  logic [EXP_W+MANT_W:0]     b,
  output logic                      busy,
  output logic                      done,
  output logic [EXP_W+MANT_W:0]     result
`ifdef FP_DIV_ZERO_CHECK_EN
  ,
  output logic                      div_by_zero
`endif
);

  // Quotient / remainder width: integer bit plus MANT_W+1 fraction bits.
  localparam int QW    = MANT_W + 2;
  localparam int CNT_W = $clog2(MANT_W + 3);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MANT_W + 1);
  localparam logic [EXP_W-1:0] BIAS_E    = EXP_W'(BIAS);
  localparam logic [EXP_W-1:0] ONE_E     = EXP_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              sign_reg;
  // Only the low EXP_W bits of the biased exponent difference are ever observable,
  // so the wrapped value is kept directly.
  logic [EXP_W-1:0]  exp_reg;
  logic [QW-1:0]     rem_reg;
  logic [MANT_W:0]   div_reg;
  logic [QW-1:0]     q_reg;
`ifdef FP_DIV_ZERO_CHECK_EN
  logic              zero_reg;
  logic              b_is_zero;
`endif

  logic              rem_ge;
  logic [QW-1:0]     rem_sub;
  logic [QW-1:0]     rem_sel;
  logic [QW-1:0]     rem_next;
  logic [QW-1:0]     q_next;
  logic [EXP_W-1:0]  exp_in;
  logic [EXP_W-1:0]  exp_norm;
  logic [MANT_W-1:0] frac_norm;
  logic [EXP_W+MANT_W:0] result_next;

  assign busy = (state_reg != S_IDLE);

`ifdef FP_DIV_ZERO_CHECK_EN
  assign b_is_zero = (b[EXP_W+MANT_W-1:0] == '0);
`endif

  // One restoring-division step, operand exponent math and the normalisation mux.
  always_comb begin
    rem_sub  = rem_reg - {1'b0, div_reg};
    rem_ge   = (rem_reg >= {1'b0, div_reg});
    rem_sel  = rem_ge ? rem_sub : rem_reg;
    // Remainder stays below 2*div, so the shifted value always fits in QW bits.
    rem_next = rem_sel << 1;
    q_next   = {q_reg[QW-2:0], rem_ge};
    exp_in   = a[EXP_W+MANT_W-1:MANT_W] - b[EXP_W+MANT_W-1:MANT_W] + BIAS_E;
    // Quotient lies in (0.5, 2): either the integer bit is set, or the next bit is.
    if (q_reg[QW-1]) begin
      frac_norm = q_reg[MANT_W:1];
      exp_norm  = exp_reg;
    end else begin
      frac_norm = q_reg[MANT_W-1:0];
      exp_norm  = exp_reg - ONE_E;
    end
    result_next = {sign_reg, exp_norm, frac_norm};
`ifdef FP_DIV_ZERO_CHECK_EN
    if (zero_reg) begin
      result_next = {sign_reg, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end
`endif
  end

  // Control FSM and iterative datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      sign_reg  <= 1'b0;
      exp_reg   <= '0;
      rem_reg   <= '0;
      div_reg   <= '0;
      q_reg     <= '0;
`ifdef FP_DIV_ZERO_CHECK_EN
      zero_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_DIV;
            cnt_reg   <= '0;
            sign_reg  <= a[EXP_W+MANT_W] ^ b[EXP_W+MANT_W];
            exp_reg   <= exp_in;
            rem_reg   <= {1'b0, 1'b1, a[MANT_W-1:0]};
            div_reg   <= {1'b1, b[MANT_W-1:0]};
            q_reg     <= '0;
`ifdef FP_DIV_ZERO_CHECK_EN
            zero_reg  <= b_is_zero;
`endif
          end
        end
        S_DIV: begin
`ifdef FP_DIV_ZERO_CHECK_EN
          if (zero_reg) begin
            state_reg <= S_NORM;
          end else begin
            rem_reg <= rem_next;
            q_reg   <= q_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_ITER) begin
              state_reg <= S_NORM;
            end
          end
`else
          rem_reg <= rem_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_ITER) begin
            state_reg <= S_NORM;
          end
`endif
        end
        S_NORM: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Result, done pulse and status flag, updated only when an operation completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      result      <= '0;
`ifdef FP_DIV_ZERO_CHECK_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= (state_reg == S_NORM);
      if (state_reg == S_NORM) begin
        result      <= result_next;
`ifdef FP_DIV_ZERO_CHECK_EN
        div_by_zero <= zero_reg;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fp_divider_seq.sv
// tb_fp_divider_seq: directed bench for fp_divider_seq with hand-computed quotients.
// Honours the FP_DIV_ZERO_CHECK_EN build macro for the divide-by-zero scenario.
module tb_fp_divider_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
`ifdef FP_DIV_ZERO_CHECK_EN
  logic        div_by_zero;
`endif

  int checks = 0;
  int errors = 0;

  fp_divider_seq #(.EXP_W(8), .MANT_W(23), .BIAS(127)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef FP_DIV_ZERO_CHECK_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; returns at the falling edge where done is seen high.
  // edges = number of rising edges after the accept edge (-1 on timeout).
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv,
                       output logic [31:0] res, output int edges);
    a = ta;
    b = tbv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = -1;
    res = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        edges = k;
        res = result;
        break;
      end
    end
    $display("op %08h / %08h -> %08h after %0d edges", ta, tbv, res, edges);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b result=%08h, required 0/0/00000000", busy, done, result);
    end
`ifdef FP_DIV_ZERO_CHECK_EN
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_dbz: div_by_zero=%b, required 0", div_by_zero);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_basic();
    int edges;
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_after_accept: busy=%b done=%b, required 1/0", busy, done);
    end
    edges = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        edges = k;
        break;
      end
    end
    $display("op 40c00000 / 40000000 -> %08h after %0d edges", result, edges);
    checks++;
    if (edges !== 26) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, required 26", edges);
    end
    checks++;
    if (result !== 32'h40400000) begin
      errors++;
      $display("FAIL basic_result: got %08h, required 40400000", result);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: busy=%b, required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== 32'h40400000) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b result=%08h, required 0 / 40400000", done, result);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vq [8];
    logic [31:0] res;
    int edges;
    va[0] = 32'h3F800000; vb[0] = 32'h40400000; vq[0] = 32'h3EAAAAAA; // 1/3 truncated
    va[1] = 32'h3F800000; vb[1] = 32'h3F800000; vq[1] = 32'h3F800000; // 1/1
    va[2] = 32'hBFC00000; vb[2] = 32'h3F000000; vq[2] = 32'hC0400000; // -1.5/0.5
    va[3] = 32'h40400000; vb[3] = 32'h40000000; vq[3] = 32'h3FC00000; // 3/2
    va[4] = 32'h40000000; vb[4] = 32'h40400000; vq[4] = 32'h3F2AAAAA; // 2/3
    va[5] = 32'h7F000000; vb[5] = 32'h00800000; vq[5] = 32'h3E000000; // exponent wraps high
    va[6] = 32'h00800000; vb[6] = 32'h7F000000; vq[6] = 32'h41000000; // exponent wraps low
    va[7] = 32'h00000000; vb[7] = 32'h3FC00000; vq[7] = 32'h7FAAAAAA; // zero as normal, exp 0-1
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], res, edges);
      checks++;
      if (res !== vq[i] || edges !== 26) begin
        errors++;
        $display("FAIL vector_%0d: got %08h after %0d edges, required %08h after 26", i, res, edges, vq[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start();
    logic [31:0] res;
    int edges;
    int extra;
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = -1;
    res = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 5 || k == 20) begin
        a = 32'h3F800000;
        b = 32'h40400000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        edges = k;
        res = result;
        break;
      end
    end
    start = 1'b0;
    $display("op 40c00000 / 40000000 with stray starts -> %08h after %0d edges", res, edges);
    checks++;
    if (res !== 32'h40400000 || edges !== 26) begin
      errors++;
      $display("FAIL ignored_start_result: got %08h after %0d edges, required 40400000 after 26", res, edges);
    end
    extra = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_no_extra_op: extra dones=%0d busy=%b, required 0/0", extra, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res1;
    logic [31:0] res2;
    int e1;
    int e2;
    do_op(32'h40C00000, 32'h40000000, res1, e1);
    do_op(32'h3F800000, 32'h40400000, res2, e2);
    checks++;
    if (res1 !== 32'h40400000 || e1 !== 26) begin
      errors++;
      $display("FAIL b2b_first: got %08h after %0d edges, required 40400000 after 26", res1, e1);
    end
    checks++;
    if (res2 !== 32'h3EAAAAAA || e2 !== 26) begin
      errors++;
      $display("FAIL b2b_second: got %08h after %0d edges, required 3eaaaaaa after 26", res2, e2);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int edges;
    int stray;
    do_op(32'h3F800000, 32'h3F800000, res, edges);
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset asserted mid-operation");
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_state: busy=%b done=%b result=%08h, required 0/0/00000000", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) stray++;
    end
    checks++;
    if (stray !== 0 || result !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_no_done: dones=%0d result=%08h, required 0 / 00000000", stray, result);
    end
    do_op(32'hBFC00000, 32'h3F000000, res, edges);
    checks++;
    if (res !== 32'hC0400000 || edges !== 26) begin
      errors++;
      $display("FAIL async_reset_fresh_op: got %08h after %0d edges, required c0400000 after 26", res, edges);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    logic [31:0] res;
    int edges;
`ifdef FP_DIV_ZERO_CHECK_EN
    do_op(32'h3F800000, 32'h80000000, res, edges);
    checks++;
    if (res !== 32'hFF800000 || edges !== 2 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL div_zero_inf: got %08h after %0d edges dbz=%b, required ff800000 after 2 dbz=1",
               res, edges, div_by_zero);
    end
    @(negedge clk);
    do_op(32'h40C00000, 32'h40000000, res, edges);
    checks++;
    if (res !== 32'h40400000 || edges !== 26 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL div_zero_clear: got %08h after %0d edges dbz=%b, required 40400000 after 26 dbz=0",
               res, edges, div_by_zero);
    end
`else
    // Without the check, a zero divisor is an ordinary operand with hidden 1.
    do_op(32'h3F800000, 32'h80000000, res, edges);
    checks++;
    if (res !== 32'hFF000000 || edges !== 26) begin
      errors++;
      $display("FAIL div_zero_plain: got %08h after %0d edges, required ff000000 after 26", res, edges);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    test_div_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
